k10_mem_stage: RTL

- K10 memory-access stage (MEM): takes EX/MEM pipeline values, performs loads/stores over the data bus, and holds the MEM/WB pipeline register that feeds writeback.
- Handles store byte-enables and lane replication, load lane extraction with sign/zero extension, misalignment detection and bus errors.
- Stalls upstream stages while a bus access is outstanding.

---
 rtl/k10_mem_stage.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/k10_mem_stage.sv
// K10 MEM stage: data-bus loads/stores with lane steering, fault traps and the MEM/WB register.
// Build option K10_MISALIGN_TRAP_EN: trap misaligned H/W accesses; otherwise low address bits are forced to alignment.
package k10_pkg;
  typedef struct packed {
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       mem_unsigned;
  } ctrl_t;
endpackage

module k10_mem_stage
  import k10_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_flush,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_csr_rdata,
  input  logic [31:0] i_pc,
  input  logic [4:0]  i_rd_addr,
  input  ctrl_t       i_ctrl,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  input  logic        i_dmem_err,
  output logic        o_wb_valid,
  output logic [31:0] o_wb_alu_result,
  output logic [31:0] o_wb_mem_rdata,
  output logic [31:0] o_wb_csr_rdata,
  output logic [31:0] o_wb_pc,
  output logic [4:0]  o_wb_rd_addr,
  output ctrl_t       o_wb_ctrl,
  output logic        o_exc_valid,
  output logic [3:0]  o_exc_cause,
  output logic [31:0] o_exc_tval
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT_GNT = 2'd1, S_WAIT_RSP = 2'd2} state_t;
  localparam logic [31:0] TMO_LAST = (RSP_TIMEOUT == 0) ? 32'd0 : 32'(RSP_TIMEOUT - 1);

  state_t      r_state, w_next;
  logic [1:0]  w_a, w_lane, r_lane;
  logic        w_mem_op, w_misalign, w_issue, w_rsp, w_tmo, w_kill, r_killed;
  logic [3:0]  w_be, r_bus_be;
  logic [31:0] w_wdata, w_load, r_tmo_cnt;
  logic [15:0] w_shift;
  logic [31:0] r_bus_addr, r_bus_wdata, r_tval, r_alu, r_csr, r_pc;
  logic        r_bus_we;
  logic [4:0]  r_rd;
  ctrl_t       r_ctrl;
  logic        r_wb_valid, r_exc_valid;
  logic [31:0] r_wb_alu, r_wb_mem, r_wb_csr, r_wb_pc, r_exc_tval;
  logic [4:0]  r_wb_rd;
  ctrl_t       r_wb_ctrl;
  logic [3:0]  r_exc_cause;

  assign w_a      = i_alu_result[1:0];
  assign w_mem_op = i_valid & ~i_flush & (i_ctrl.mem_read | i_ctrl.mem_write);

`ifdef K10_MISALIGN_TRAP_EN
  always_comb begin
    case (i_ctrl.mem_size)
      2'd0:    w_misalign = 1'b0;
      2'd1:    w_misalign = w_a[0];
      default: w_misalign = (w_a != 2'b00);
    endcase
  end
  assign w_lane = w_a;
`else
  assign w_misalign = 1'b0;
  always_comb begin
    case (i_ctrl.mem_size)
      2'd0:    w_lane = w_a;
      2'd1:    w_lane = {w_a[1], 1'b0};
      default: w_lane = 2'b00;
    endcase
  end
`endif

  always_comb begin
    case (i_ctrl.mem_size)
      2'd0:    begin w_be = 4'b0001 << w_lane;           w_wdata = {4{i_store_data[7:0]}};  end
      2'd1:    begin w_be = 4'b0011 << {w_lane[1], 1'b0}; w_wdata = {2{i_store_data[15:0]}}; end
      default: begin w_be = 4'b1111;                      w_wdata = i_store_data;            end
    endcase
  end

  assign w_issue = (r_state == S_IDLE) & w_mem_op & ~w_misalign;
  assign w_rsp   = (r_state == S_WAIT_RSP) & i_dmem_rvalid;
  // A response arriving in the same cycle as the timeout still wins.
  assign w_tmo   = (RSP_TIMEOUT != 0) && (r_state != S_IDLE) && (r_tmo_cnt == TMO_LAST) && !w_rsp;
  assign w_kill  = r_killed | i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_issue) w_next = i_dmem_gnt ? S_WAIT_RSP : S_WAIT_GNT;
      S_WAIT_GNT: if (w_tmo) w_next = S_IDLE; else if (i_dmem_gnt) w_next = S_WAIT_RSP;
      S_WAIT_RSP: if (w_rsp || w_tmo) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_stall      = 1'b0;
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_dmem_addr  = 32'd0;
    o_dmem_be    = 4'd0;
    o_dmem_wdata = 32'd0;
    case (r_state)
      S_IDLE: if (w_issue) begin
        o_stall      = 1'b1;
        o_dmem_req   = 1'b1;
        o_dmem_we    = i_ctrl.mem_write;
        o_dmem_addr  = {i_alu_result[31:2], 2'b00};
        o_dmem_be    = w_be;
        o_dmem_wdata = w_wdata;
      end
      S_WAIT_GNT, S_WAIT_RSP: begin
        o_stall      = ~w_rsp & ~w_tmo;
        o_dmem_req   = (r_state == S_WAIT_GNT);
        o_dmem_we    = r_bus_we;
        o_dmem_addr  = r_bus_addr;
        o_dmem_be    = r_bus_be;
        o_dmem_wdata = r_bus_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmo_cnt <= 32'd0;
      r_killed  <= 1'b0;
    end else if (r_state == S_IDLE || w_next == S_IDLE) begin
      r_tmo_cnt <= 32'd0;
      r_killed  <= 1'b0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 32'd1;
      if (i_flush) r_killed <= 1'b1;
    end
  end

  // The whole instruction is captured at issue so the response needs nothing from EX/MEM.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bus_addr  <= 32'd0;
      r_bus_we    <= 1'b0;
      r_bus_be    <= 4'd0;
      r_bus_wdata <= 32'd0;
      r_lane      <= 2'd0;
      r_tval      <= 32'd0;
      r_alu       <= 32'd0;
      r_csr       <= 32'd0;
      r_pc        <= 32'd0;
      r_rd        <= 5'd0;
      r_ctrl      <= '0;
    end else if (w_issue) begin
      r_bus_addr  <= {i_alu_result[31:2], 2'b00};
      r_bus_we    <= i_ctrl.mem_write;
      r_bus_be    <= w_be;
      r_bus_wdata <= w_wdata;
      r_lane      <= w_lane;
      r_tval      <= i_alu_result;
      r_alu       <= i_alu_result;
      r_csr       <= i_csr_rdata;
      r_pc        <= i_pc;
      r_rd        <= i_rd_addr;
      r_ctrl      <= i_ctrl;
    end
  end

  assign w_shift = 16'(i_dmem_rdata >> {r_lane, 3'b000});

  always_comb begin
    case (r_ctrl.mem_size)
      2'd0:    w_load = r_ctrl.mem_unsigned ? {24'd0, w_shift[7:0]} : {{24{w_shift[7]}}, w_shift[7:0]};
      2'd1:    w_load = r_ctrl.mem_unsigned ? {16'd0, w_shift} : {{16{w_shift[15]}}, w_shift};
      default: w_load = i_dmem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wb_valid  <= 1'b0;
      r_wb_alu    <= 32'd0;
      r_wb_mem    <= 32'd0;
      r_wb_csr    <= 32'd0;
      r_wb_pc     <= 32'd0;
      r_wb_rd     <= 5'd0;
      r_wb_ctrl   <= '0;
      r_exc_valid <= 1'b0;
      r_exc_cause <= 4'd0;
      r_exc_tval  <= 32'd0;
    end else begin
      r_wb_valid  <= 1'b0;
      r_exc_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        if (i_valid && !i_flush) begin
          if (!(i_ctrl.mem_read || i_ctrl.mem_write)) begin
            r_wb_valid <= 1'b1;
            r_wb_alu   <= i_alu_result;
            r_wb_mem   <= 32'd0;
            r_wb_csr   <= i_csr_rdata;
            r_wb_pc    <= i_pc;
            r_wb_rd    <= i_rd_addr;
            r_wb_ctrl  <= i_ctrl;
          end else if (w_misalign) begin
            r_exc_valid <= 1'b1;
            r_exc_cause <= i_ctrl.mem_write ? 4'd6 : 4'd4;
            r_exc_tval  <= i_alu_result;
          end
        end
      end else if (w_rsp && !w_kill) begin
        if (i_dmem_err) begin
          r_exc_valid <= 1'b1;
          r_exc_cause <= r_ctrl.mem_write ? 4'd7 : 4'd5;
          r_exc_tval  <= r_tval;
        end else begin
          r_wb_valid <= 1'b1;
          r_wb_alu   <= r_alu;
          r_wb_mem   <= r_ctrl.mem_read ? w_load : 32'd0;
          r_wb_csr   <= r_csr;
          r_wb_pc    <= r_pc;
          r_wb_rd    <= r_rd;
          r_wb_ctrl  <= r_ctrl;
        end
      end else if (w_tmo && !w_kill) begin
        r_exc_valid <= 1'b1;
        r_exc_cause <= r_ctrl.mem_write ? 4'd7 : 4'd5;
        r_exc_tval  <= r_tval;
      end
    end
  end

  assign o_wb_valid      = r_wb_valid;
  assign o_wb_alu_result = r_wb_alu;
  assign o_wb_mem_rdata  = r_wb_mem;
  assign o_wb_csr_rdata  = r_wb_csr;
  assign o_wb_pc         = r_wb_pc;
  assign o_wb_rd_addr    = r_wb_rd;
  assign o_wb_ctrl       = r_wb_ctrl;
  assign o_exc_valid     = r_exc_valid;
  assign o_exc_cause     = r_exc_cause;
  assign o_exc_tval      = r_exc_tval;

endmodule
